// File: rtl/sbus_sram_responder.sv
// Strobe/ready bus responder driving a 32-bit asynchronous SRAM with programmable wait states.
// Optional misalignment rejection is compiled in with `define SBUS_SRAM_ALIGN_CHECK_EN.
module sbus_sram_responder #(
    parameter int A_WIDTH = 32,
    parameter int SRAM_AW = 20,
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [A_WIDTH-1:0] s_a,
    input  logic [31:0]        s_din,
    output logic [31:0]        s_dout,
    input  logic               s_strobe,
    input  logic [3:0]         s_wen,
    input  logic [1:0]         s_size,
    input  logic               s_rw,
    output logic               s_ready,
    output logic               s_err,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [3:0]         sram_be_n,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic [31:0]        sram_dq_o,
    output logic               sram_dq_oe,
    input  logic [31:0]        sram_dq_i
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD      = 3'd1;
    localparam logic [2:0] S_WR      = 3'd2;
    localparam logic [2:0] S_WR_HOLD = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int CW       = $clog2(MAX_WAIT + 1);

    logic [2:0]    state;
    logic [CW-1:0] wait_cnt;
    logic          misaligned;
    logic          err_q;

`ifdef SBUS_SRAM_ALIGN_CHECK_EN
    always_comb begin
        misaligned = 1'b0;
        if (s_size == 2'd2 && s_a[1:0] != 2'b00)
            misaligned = 1'b1;
        else if (s_size == 2'd1 && s_a[0])
            misaligned = 1'b1;
    end
    assign s_err = err_q;
`else
    assign misaligned = 1'b0;
    assign s_err      = 1'b0;
`endif

    // Byte-offset bits, upper aliasing bits and size only matter to the optional check.
    logic unused_ok;
    assign unused_ok = ^{s_a[A_WIDTH-1:SRAM_AW+2], s_a[1:0], s_size, err_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            err_q      <= 1'b0;
            s_ready    <= 1'b0;
            s_dout     <= '0;
            sram_addr  <= '0;
            sram_be_n  <= '1;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_dq_o  <= '0;
            sram_dq_oe <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (s_strobe) begin
                        if (misaligned) begin
                            state   <= S_DONE;
                            s_ready <= 1'b1;
                            err_q   <= 1'b1;
                        end else if (!s_rw) begin
                            state     <= S_RD;
                            wait_cnt  <= CW'(RD_WAIT - 1);
                            sram_addr <= s_a[SRAM_AW+1:2];
                            sram_be_n <= '0;
                            sram_ce_n <= 1'b0;
                            sram_oe_n <= 1'b0;
                        end else if (s_wen != 4'b0000) begin
                            state      <= S_WR;
                            wait_cnt   <= CW'(WR_WAIT - 1);
                            sram_addr  <= s_a[SRAM_AW+1:2];
                            sram_be_n  <= ~s_wen;
                            sram_dq_o  <= s_din;
                            sram_ce_n  <= 1'b0;
                            sram_we_n  <= 1'b0;
                            sram_dq_oe <= 1'b1;
                        end else begin
                            // Empty byte mask: acknowledge without touching the SRAM pins.
                            state   <= S_DONE;
                            s_ready <= 1'b1;
                        end
                    end
                end
                S_RD: begin
                    if (wait_cnt == '0) begin
                        state     <= S_DONE;
                        s_ready   <= 1'b1;
                        s_dout    <= sram_dq_i;
                        sram_be_n <= '1;
                        sram_ce_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - CW'(1);
                    end
                end
                S_WR: begin
                    if (wait_cnt == '0) begin
                        state     <= S_WR_HOLD;
                        sram_we_n <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - CW'(1);
                    end
                end
                S_WR_HOLD: begin
                    // Data and chip enable held one cycle past we_n rising.
                    state      <= S_DONE;
                    s_ready    <= 1'b1;
                    sram_be_n  <= '1;
                    sram_ce_n  <= 1'b1;
                    sram_dq_oe <= 1'b0;
                end
                S_DONE: begin
                    state   <= S_IDLE;
                    s_ready <= 1'b0;
                    err_q   <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sbus_sram_responder.sv
// Self-checking bench for sbus_sram_responder: directed cases plus randomized
// transactions checked against a word-array reference memory and cycle-level timing rules.
module tb_sbus_sram_responder;

    localparam int RDW = 2;
    localparam int WRW = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_a;
    logic [31:0] s_din;
    logic [31:0] s_dout;
    logic        s_strobe;
    logic [3:0]  s_wen;
    logic [1:0]  s_size;
    logic        s_rw;
    logic        s_ready;
    logic        s_err;
    logic [19:0] sram_addr;
    logic [3:0]  sram_be_n;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic [31:0] sram_dq_o;
    logic        sram_dq_oe;
    logic [31:0] sram_dq_i;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_dout;

    always #5 clk = ~clk;

    sbus_sram_responder #(
        .A_WIDTH(32),
        .SRAM_AW(20),
        .RD_WAIT(RDW),
        .WR_WAIT(WRW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s_a(s_a),
        .s_din(s_din),
        .s_dout(s_dout),
        .s_strobe(s_strobe),
        .s_wen(s_wen),
        .s_size(s_size),
        .s_rw(s_rw),
        .s_ready(s_ready),
        .s_err(s_err),
        .sram_addr(sram_addr),
        .sram_be_n(sram_be_n),
        .sram_ce_n(sram_ce_n),
        .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n),
        .sram_dq_o(sram_dq_o),
        .sram_dq_oe(sram_dq_oe),
        .sram_dq_i(sram_dq_i)
    );

    // Power-on contents shared by the SRAM model and the reference memory.
    function automatic logic [31:0] fill(input int unsigned w);
        return (w * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    endfunction

    // Asynchronous SRAM pad model.
    logic [31:0] sram_mem [int unsigned];

    function automatic logic [31:0] sram_read(input logic [19:0] w);
        int unsigned k;
        k = w;
        if (sram_mem.exists(k)) return sram_mem[k];
        return fill(k);
    endfunction

    always @(*) begin
        if (!sram_ce_n && !sram_oe_n) sram_dq_i = sram_read(sram_addr);
        else                          sram_dq_i = 32'h0BAD_F00D;
    end

    always @(posedge sram_we_n) begin
        if (sram_ce_n === 1'b0 && sram_dq_oe === 1'b1) begin
            int unsigned k;
            logic [31:0] v;
            k = sram_addr;
            v = sram_read(sram_addr);
            for (int b = 0; b < 4; b++)
                if (!sram_be_n[b]) v[8*b +: 8] = sram_dq_o[8*b +: 8];
            sram_mem[k] = v;
        end
    end

    // Reference memory: what each word must hold after the requests issued so far.
    logic [31:0] ref_mem [int unsigned];

    function automatic logic [31:0] ref_read(input int unsigned k);
        if (ref_mem.exists(k)) return ref_mem[k];
        return fill(k);
    endfunction

    function automatic bit misal(input logic [1:0] size, input logic [31:0] a);
`ifdef SBUS_SRAM_ALIGN_CHECK_EN
        return (size == 2'd2 && a[1:0] != 2'b00) || (size == 2'd1 && a[0]);
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        s_strobe = 1'b0;
        s_a      = $urandom;
        s_din    = $urandom;
        repeat (n) begin
            @(negedge clk);
            chk("idle_ready", {31'b0, s_ready}, 32'd0);
            chk("idle_ce", {31'b0, sram_ce_n}, 32'd1);
        end
    endtask

    // Issues one request in the next cycle and checks every cycle up to its ready pulse.
    task automatic xact(input logic rw, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] wen, input logic [1:0] size, input bit scramble);
        int lat;
        bit mis;
        int unsigned k;
        logic [19:0] w;
        logic [31:0] rdexp;
        logic [31:0] v;
        w   = a[21:2];
        k   = w;
        mis = misal(size, a);
        if (mis)             lat = 1;
        else if (!rw)        lat = RDW + 1;
        else if (wen == '0)  lat = 1;
        else                 lat = WRW + 2;
        rdexp = ref_read(k);

        @(posedge clk); #1;
        s_strobe = 1'b1;
        s_rw     = rw;
        s_a      = a;
        s_din    = d;
        s_wen    = wen;
        s_size   = size;
        @(negedge clk);
        chk("c0_ready", {31'b0, s_ready}, 32'd0);
        chk("c0_ce", {31'b0, sram_ce_n}, 32'd1);

        for (int c = 1; c <= lat; c++) begin
            @(posedge clk); #1;
            if (scramble) begin
                s_a      = $urandom;
                s_din    = $urandom;
                s_wen    = 4'($urandom_range(0, 15));
                s_rw     = ~rw;
                s_strobe = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            chk("oe_we_excl", {31'b0, sram_oe_n | sram_we_n}, 32'd1);
            if (c < lat) begin
                chk("busy_ready", {31'b0, s_ready}, 32'd0);
                chk("busy_ce", {31'b0, sram_ce_n}, 32'd0);
                chk("busy_addr", {12'b0, sram_addr}, {12'b0, w});
                if (!rw) begin
                    chk("rd_oe", {31'b0, sram_oe_n}, 32'd0);
                    chk("rd_we", {31'b0, sram_we_n}, 32'd1);
                    chk("rd_be", {28'b0, sram_be_n}, 32'd0);
                    chk("rd_dqoe", {31'b0, sram_dq_oe}, 32'd0);
                end else begin
                    chk("wr_oe", {31'b0, sram_oe_n}, 32'd1);
                    chk("wr_we", {31'b0, sram_we_n}, (c <= WRW) ? 32'd0 : 32'd1);
                    chk("wr_dqoe", {31'b0, sram_dq_oe}, 32'd1);
                    chk("wr_dq", sram_dq_o, d);
                    chk("wr_be", {28'b0, sram_be_n}, {28'b0, ~wen});
                end
            end else begin
                chk("done_ready", {31'b0, s_ready}, 32'd1);
                chk("done_err", {31'b0, s_err}, {31'b0, mis});
                chk("done_ctl", {28'b0, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 32'b1110);
                if (!rw && !mis) exp_dout = rdexp;
                chk("done_dout", s_dout, exp_dout);
            end
        end

        if (rw && !mis && wen != '0) begin
            v = ref_read(k);
            for (int b = 0; b < 4; b++)
                if (wen[b]) v[8*b +: 8] = d[8*b +: 8];
            ref_mem[k] = v;
        end
    endtask

    initial begin
        logic [31:0] a;
        rst = 1'b1; s_strobe = 1'b0; s_a = '0; s_din = '0; s_wen = '0; s_size = '0; s_rw = 1'b0;
        exp_dout = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'b0, s_ready}, 32'd0);
        chk("rst_err", {31'b0, s_err}, 32'd0);
        chk("rst_dout", s_dout, 32'd0);
        chk("rst_addr", {12'b0, sram_addr}, 32'd0);
        chk("rst_ctl", {27'b0, sram_be_n, sram_ce_n}, 32'h1F);
        chk("rst_oewe", {30'b0, sram_oe_n, sram_we_n}, 32'd3);
        chk("rst_dq", {sram_dq_o[30:0], sram_dq_oe}, 32'd0);
        rst = 1'b0;

        // Directed read: word 4 preloaded with a known value.
        sram_mem[4] = 32'hDEAD_BEEF;
        ref_mem[4]  = 32'hDEAD_BEEF;
        xact(1'b0, 32'h8000_0010, 32'h0, 4'h0, 2'd2, 1'b0);
        chk("tp_read_dout", s_dout, 32'hDEAD_BEEF);
        chk("tp_read_addr", {12'b0, sram_addr}, 32'h0000_0004);

        // Directed partial write, then read back.
        xact(1'b1, 32'h8000_0020, 32'h1234_5678, 4'b0011, 2'd2, 1'b0);
        xact(1'b0, 32'h8000_0020, 32'h0, 4'h0, 2'd2, 1'b0);
        chk("tp_write_rb", s_dout, {fill(8) & 32'hFFFF_0000} | 32'h0000_5678);

        // Back-to-back with strobe held between requests.
        xact(1'b0, 32'h0000_0004, 32'h0, 4'h0, 2'd2, 1'b0);
        xact(1'b1, 32'h0000_0004, 32'hA5A5_C3C3, 4'b1111, 2'd2, 1'b0);
        xact(1'b0, 32'h0000_0004, 32'h0, 4'h0, 2'd2, 1'b0);
        chk("b2b_rb", s_dout, 32'hA5A5_C3C3);

        // Empty byte mask write: immediate ack, memory untouched.
        xact(1'b1, 32'h0000_0004, 32'hFFFF_FFFF, 4'b0000, 2'd2, 1'b0);
        xact(1'b0, 32'h0000_0004, 32'h0, 4'h0, 2'd2, 1'b0);
        chk("nowen_rb", s_dout, 32'hA5A5_C3C3);

        // Reset during cycle 1 of a write.
        @(posedge clk); #1;
        s_strobe = 1'b1; s_rw = 1'b1; s_a = 32'h0000_0040; s_din = 32'hCAFE_F00D; s_wen = 4'hF; s_size = 2'd2;
        @(posedge clk); #1;
        s_strobe = 1'b0;
        @(negedge clk);
        chk("rstw_c1_we", {31'b0, sram_we_n}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        exp_dout = '0;
        chk("rstw_ctl", {28'b0, sram_ce_n, sram_we_n, sram_dq_oe, s_ready}, 32'b1100);
        chk("rstw_dout", s_dout, 32'd0);
        chk("rstw_be", {28'b0, sram_be_n}, 32'hF);
        idle(4);
        xact(1'b0, 32'h0000_0080, 32'h0, 4'h0, 2'd2, 1'b0);
        chk("rstw_after_rd", s_dout, fill(32'h20));

        // Misaligned word read.
        xact(1'b0, 32'h8000_0002, 32'h0, 4'h0, 2'd2, 1'b0);

        // Randomized traffic over a small aliased word window.
        for (int i = 0; i < 80; i++) begin
            a = ($urandom & 32'hFFC0_0000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            xact(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
        end
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sbus_sram_responder.md
Name: sbus_sram_responder

Overview:
- Target (responder) end of the on-chip simple strobe/ready memory bus driven by the L1 data cache and its uncached path.
- Accepts one request at a time: address, write data, byte enables, size and read/write. Executes it on a 32-bit asynchronous external SRAM (ThinPAD-style BaseRAM/ExtRAM) using programmable wait states.
- Completes each request with a single-cycle ready pulse carrying read data.

Parameters:
- A_WIDTH, 32, bus byte-address width.
- SRAM_AW, 20, SRAM word-address width; word address = s_a[SRAM_AW+1:2], upper bits ignored (aliasing).
- RD_WAIT, 2, cycles ce_n/oe_n held low before read data is sampled (≥1).
- WR_WAIT, 2, cycles we_n held low per write (≥1).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- s_a  in  A_WIDTH  byte address of request
- s_din  in  32  write data (initiator→responder)
- s_dout  out  32  read data, valid while s_ready=1
- s_strobe  in  1  request valid; held until s_ready
- s_wen  in  4  byte enables for writes
- s_size  in  2  0=byte, 1=half, 2=word (alignment check only)
- s_rw  in  1  1=write, 0=read
- s_ready  out  1  one-cycle completion pulse
- s_err  out  1  misalignment error, coincident with s_ready (feature-gated)
- sram_addr  out  SRAM_AW  word address
- sram_be_n  out  4  byte enables, active-low
- sram_ce_n / sram_oe_n / sram_we_n  out  1 each  SRAM controls, active-low
- sram_dq_o  out  32  write data to pad
- sram_dq_oe  out  1  pad output enable (1 = drive)
- sram_dq_i  in  32  data from pad

Behaviour:
- All outputs registered.
- Reset values: s_ready=0, s_err=0, s_dout=0, sram_addr=0, sram_be_n=4'hF, ce_n=oe_n=we_n=1, sram_dq_o=0, sram_dq_oe=0, state=IDLE.
- States: IDLE, RD, WR, WR_HOLD, DONE. A wait counter is loaded on entry to RD/WR.
- IDLE: samples s_strobe each cycle. Call the sampling cycle 0. On s_strobe=1, latch addr, data, be_n=~s_wen.
  - Read → RD.
  - Write with s_wen≠0 → WR.
  - Write with s_wen==0 → DONE directly; no SRAM pins toggle.
- Read timing:
  - Cycles 1..RD_WAIT: ce_n=0, oe_n=0, be_n=0000, dq_oe=0.
  - sram_dq_i is captured into s_dout at the end of cycle RD_WAIT.
  - Cycle RD_WAIT+1: DONE, s_ready=1, ce_n=oe_n=1.
  - The full 32-bit word is always returned; lane extraction belongs to the initiator.
- Write timing:
  - Cycles 1..WR_WAIT: ce_n=0, we_n=0, dq_oe=1, addr/data/be stable.
  - Cycle WR_WAIT+1: WR_HOLD; we_n=1, ce_n=0, dq_oe=1 (data hold).
  - Cycle WR_WAIT+2: DONE, s_ready=1, all controls deasserted, dq_oe=0.
- oe_n and we_n are never low in the same cycle. dq_oe=1 only in WR/WR_HOLD.
- DONE always returns to IDLE, so there is a minimum one-cycle gap between s_ready and the next acceptance. The initiator must drop or change the request in the cycle after s_ready.
- s_strobe dropping mid-transaction: ignored. The transaction completes and s_ready still pulses.
- Request inputs changing mid-transaction: ignored, since the request is latched at acceptance.
- Reset asserted in any state: on that edge all outputs return to reset values (we_n=1 immediately), the in-flight request is discarded, and no s_ready is produced.
- s_dout holds its last captured value outside reads. On writes it is unchanged.

Optional Feature:
- Macro: SBUS_SRAM_ALIGN_CHECK_EN.
- Defined: in IDLE, a misaligned request (size=2 and s_a[1:0]≠0, or size=1 and s_a[0]=1) goes straight to DONE with no SRAM activity. s_ready=1 and s_err=1 in that cycle, and s_dout is unchanged.
- Undefined: s_err is tied 0, s_size is unused, and misaligned requests execute at the truncated word address.

Test Plan:
- Read, RD_WAIT=2: s_a=0x8000_0010, sram_dq_i=0xDEADBEEF → sram_addr=0x00004, ce_n/oe_n low in cycles 1-2, s_ready=1 with s_dout=0xDEADBEEF in cycle 3 only.
- Write, WR_WAIT=2: s_a=0x8000_0020, s_din=0x12345678, s_wen=0011 → be_n=1100, we_n low in cycles 1-2, high in cycle 3 with dq_oe=1, s_ready in cycle 4, oe_n=1 throughout.
- Back-to-back, strobe held: read then write → second acceptance no earlier than the cycle after the first s_ready; exactly one s_ready per request.
- Write with s_wen=0000 → s_ready in cycle 1; we_n and ce_n stay 1.
- rst asserted during cycle 1 of a write → next cycle we_n=1, ce_n=1, dq_oe=0, no s_ready; a subsequent read completes normally.
- With SBUS_SRAM_ALIGN_CHECK_EN: word read at s_a=0x8000_0002 → s_ready=s_err=1 in cycle 1 and ce_n never low. Without the macro: the same request reads word 0 with s_err=0.
